// File: rtl/demultiplexer4dst_if.sv
// demultiplexer4dst_if: bundle of the distributor's input handshake, the four
// output slots with their handshakes, and the drop status signals.
//   dst        one-hot destination select (1/2/4/8 -> slot 0/1/2/3)
//   in_data    word to distribute
//   in_valid   in_data/dst valid
//   in_ready   distributor can take the word this cycle
//   dst0..dst3 slot data words
//   out_valid  per-slot "holds an undelivered word"
//   out_ready  per-slot consumer take
//   err_drop   one-cycle pulse after an illegal-dst word was discarded
//   drop_count count of discarded words (0 unless DEMUX_DROP_COUNT_EN)
// Modports: slave = the distributor, master = source plus consumers.
interface demultiplexer4dst_if #(
    parameter int bus_width = 8
);
    logic [3:0]           dst;
    logic [bus_width-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [bus_width-1:0] dst0;
    logic [bus_width-1:0] dst1;
    logic [bus_width-1:0] dst2;
    logic [bus_width-1:0] dst3;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic                 err_drop;
    logic [7:0]           drop_count;

    modport slave (
        input  dst, in_data, in_valid, out_ready,
        output in_ready, dst0, dst1, dst2, dst3, out_valid, err_drop, drop_count
    );

    modport master (
        output dst, in_data, in_valid, out_ready,
        input  in_ready, dst0, dst1, dst2, dst3, out_valid, err_drop, drop_count
    );
endinterface

// File: rtl/demultiplexer4dst.sv
// demultiplexer4dst: one-source, four-destination distributor. A word taken on
// the valid/ready input is routed by a one-hot dst code into one of four
// registered output slots, each with its own independent valid/ready.
// Words with an illegal dst (zero or multiple bits set) are always accepted
// and discarded, flagged by a one-cycle err_drop pulse.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  demultiplexer4dst_if.slave (input handshake, slots, drop status)
// Optional feature: define DEMUX_DROP_COUNT_EN to build a saturating 8-bit
// counter of discarded words on drop_count; otherwise drop_count is 0.
module demultiplexer4dst #(
    parameter int bus_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    demultiplexer4dst_if.slave   bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e          state_p1 [4];
    slot_state_e          state_nxt [4];
    logic [bus_width-1:0] data_p1 [4];
    logic                 err_p1;

    logic                 legal;
    logic                 accept;
    logic [3:0]           load;
    logic [3:0]           drain;
    logic [3:0]           full;

    // Exactly one bit set.
    assign legal = (bus.dst != 4'd0) && ((bus.dst & (bus.dst - 4'd1)) == 4'd0);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            full[k] = (state_p1[k] == FULL);
        end
    end

    // A slot accepts when empty or draining this same cycle; illegal words are
    // always taken so a bad code can never wedge the shared bus.
    assign bus.in_ready = legal ? |(bus.dst & (~full | bus.out_ready)) : 1'b1;
    assign accept       = bus.in_valid & bus.in_ready;
    assign load         = (accept & legal) ? bus.dst : 4'd0;
    assign drain        = full & bus.out_ready;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_nxt[k] = state_p1[k];
            if (load[k]) begin
                state_nxt[k] = FULL;
            end else if (drain[k]) begin
                state_nxt[k] = EMPTY;
            end
        end
    end

    // ---- stage p1: slot registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                state_p1[k] <= EMPTY;
                data_p1[k]  <= '0;
            end
            err_p1 <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_p1[k] <= state_nxt[k];
                if (load[k]) begin
                    data_p1[k] <= bus.in_data;
                end
            end
            err_p1 <= accept & ~legal;
        end
    end

    assign bus.dst0      = data_p1[0];
    assign bus.dst1      = data_p1[1];
    assign bus.dst2      = data_p1[2];
    assign bus.dst3      = data_p1[3];
    assign bus.out_valid = full;
    assign bus.err_drop  = err_p1;

`ifdef DEMUX_DROP_COUNT_EN
    logic [7:0] drop_cnt_p1;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_p1 <= 8'd0;
        end else if (accept & ~legal) begin
            drop_cnt_p1 <= sat_inc(drop_cnt_p1);
        end
    end

    assign bus.drop_count = drop_cnt_p1;
`else
    assign bus.drop_count = 8'd0;
`endif

endmodule
